// File: rtl/retention_pwr_seq.sv
// retention_pwr_seq
//   Power-sequencing controller for one switchable domain holding a
//   state-retention FIFO. Orders FIFO save/restore strobes, output isolation,
//   clock gating and the power switch so retained state survives power-off.
//
// Ports
//   clk       in  : always-on clock
//   rst_n     in  : synchronous active-low reset
//   sleep_req in  : level, 1 = request power-down, 0 = request domain on
//   pwr_ack   in  : power-switch status, 1 = domain powered
//   pwr_en    out : power-switch enable
//   iso_en    out : clamp domain outputs
//   clk_en    out : domain clock-gate enable
//   save      out : one-cycle pulse to FIFO save pin
//   restore   out : one-cycle pulse to FIFO restore pin
//   wr_block  out : upstream must not access the FIFO
//   asleep    out : domain is off and retained
//   busy      out : sequencer not in ON
//   err       out : sticky power-switch timeout flag
module retention_pwr_seq #(
  parameter int unsigned QUIESCE_CYCLES = 4,
  parameter int unsigned ISO_CYCLES     = 2,
  parameter int unsigned PWR_TIMEOUT    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sleep_req,
  input  logic pwr_ack,
  output logic pwr_en,
  output logic iso_en,
  output logic clk_en,
  output logic save,
  output logic restore,
  output logic wr_block,
  output logic asleep,
  output logic busy,
  output logic err
);

  localparam int unsigned MAX_QI = (QUIESCE_CYCLES > ISO_CYCLES) ? QUIESCE_CYCLES : ISO_CYCLES;
  localparam int unsigned MAX_C  = (MAX_QI > PWR_TIMEOUT) ? MAX_QI : PWR_TIMEOUT;
  localparam int unsigned CW     = (MAX_C + 1 > 1) ? $clog2(MAX_C + 1) : 1;

  localparam logic [CW-1:0] Q_LAST = CW'(QUIESCE_CYCLES - 1);
  localparam logic [CW-1:0] I_LAST = CW'(ISO_CYCLES - 1);
  localparam logic [CW-1:0] T_CNT  = CW'(PWR_TIMEOUT);

  typedef enum logic [3:0] {
    S_ON,
    S_QUIESCE,
    S_SAVE,
    S_ISO,
    S_PWR_OFF,
    S_SLEEP,
    S_PWR_ON,
    S_RESTORE,
    S_DEISO,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout;

  logic pwr_en_q, iso_en_q, clk_en_q, save_q, restore_q;
  logic wr_block_q, asleep_q, busy_q, err_q;
  logic pwr_en_d, iso_en_d, clk_en_d, save_d, restore_d;
  logic wr_block_d, asleep_d, busy_d, err_d;

  // State, dwell counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_ON;
      cnt_q      <= '0;
      pwr_en_q   <= 1'b1;
      iso_en_q   <= 1'b0;
      clk_en_q   <= 1'b1;
      save_q     <= 1'b0;
      restore_q  <= 1'b0;
      wr_block_q <= 1'b0;
      asleep_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pwr_en_q   <= pwr_en_d;
      iso_en_q   <= iso_en_d;
      clk_en_q   <= clk_en_d;
      save_q     <= save_d;
      restore_q  <= restore_d;
      wr_block_q <= wr_block_d;
      asleep_q   <= asleep_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Next state. An ack arriving in the timeout cycle is checked first, so it wins.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_ON:      if (sleep_req) state_d = S_QUIESCE;
      S_QUIESCE: begin
        if (!sleep_req)           state_d = S_ON;
        else if (cnt_q == Q_LAST) state_d = S_SAVE;
      end
      S_SAVE:    state_d = S_ISO;
      S_ISO:     if (cnt_q == I_LAST) state_d = S_PWR_OFF;
      S_PWR_OFF: begin
        if (!pwr_ack) state_d = S_SLEEP;
        else if (cnt_q == T_CNT) begin
          timeout = 1'b1;
          state_d = S_PWR_ON;
        end
      end
      S_SLEEP:   if (!sleep_req) state_d = S_PWR_ON;
      S_PWR_ON: begin
        if (pwr_ack) state_d = S_RESTORE;
        else if (cnt_q == T_CNT) begin
          timeout = 1'b1;
          state_d = S_ERR;
        end
      end
      S_RESTORE: state_d = S_DEISO;
      S_DEISO:   if (cnt_q == I_LAST) state_d = S_ON;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_ON;
    endcase
  end

  // Dwell counter clears on any state change and saturates instead of wrapping.
  always_comb begin
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == '1)    cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CW'(1);
  end

  // Outputs decoded from the next state so they move on the same edge as it.
  always_comb begin
    pwr_en_d   = 1'b1;
    iso_en_d   = 1'b0;
    clk_en_d   = 1'b0;
    save_d     = 1'b0;
    restore_d  = 1'b0;
    wr_block_d = 1'b0;
    asleep_d   = 1'b0;
    busy_d     = (state_d != S_ON);
    err_d      = err_q | timeout;
    case (state_d)
      S_ON:      clk_en_d = 1'b1;
      S_QUIESCE: begin
        clk_en_d   = 1'b1;
        wr_block_d = 1'b1;
      end
      S_SAVE: begin
        clk_en_d   = 1'b1;
        wr_block_d = 1'b1;
        save_d     = 1'b1;
      end
      S_ISO, S_DEISO: begin
        clk_en_d   = 1'b1;
        iso_en_d   = 1'b1;
        wr_block_d = 1'b1;
      end
      S_PWR_OFF: begin
        pwr_en_d   = 1'b0;
        iso_en_d   = 1'b1;
        wr_block_d = 1'b1;
      end
      S_SLEEP: begin
        pwr_en_d   = 1'b0;
        iso_en_d   = 1'b1;
        wr_block_d = 1'b1;
        asleep_d   = 1'b1;
      end
      S_PWR_ON: begin
        iso_en_d   = 1'b1;
        wr_block_d = 1'b1;
      end
      S_RESTORE: begin
        clk_en_d   = 1'b1;
        iso_en_d   = 1'b1;
        wr_block_d = 1'b1;
        restore_d  = 1'b1;
      end
      S_ERR: begin
        iso_en_d   = 1'b1;
        wr_block_d = 1'b1;
        err_d      = 1'b1;
      end
      default: ;
    endcase
  end

  assign pwr_en   = pwr_en_q;
  assign iso_en   = iso_en_q;
  assign clk_en   = clk_en_q;
  assign save     = save_q;
  assign restore  = restore_q;
  assign wr_block = wr_block_q;
  assign asleep   = asleep_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_retention_pwr_seq.sv
// Directed bench for retention_pwr_seq (Q=4, I=2, T=16). The driver issues one
// input vector per clock edge and queues the hand-derived output vector for the
// following cycle; a monitor pops and compares on each falling edge.
module tb_retention_pwr_seq;

  logic clk = 1'b0;
  logic rst_n, sleep_req, pwr_ack;
  logic pwr_en, iso_en, clk_en, save, restore, wr_block, asleep, busy, err;

  retention_pwr_seq #(
    .QUIESCE_CYCLES(4),
    .ISO_CYCLES    (2),
    .PWR_TIMEOUT   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sleep_req(sleep_req),
    .pwr_ack  (pwr_ack),
    .pwr_en   (pwr_en),
    .iso_en   (iso_en),
    .clk_en   (clk_en),
    .save     (save),
    .restore  (restore),
    .wr_block (wr_block),
    .asleep   (asleep),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Vector order: {pwr_en, iso_en, clk_en, save, restore, wr_block, asleep, busy}
  localparam logic [7:0] V_ON = 8'b1010_0000;
  localparam logic [7:0] V_QU = 8'b1010_0101;
  localparam logic [7:0] V_SV = 8'b1011_0101;
  localparam logic [7:0] V_IS = 8'b1110_0101;
  localparam logic [7:0] V_PO = 8'b0100_0101;
  localparam logic [7:0] V_SL = 8'b0100_0111;
  localparam logic [7:0] V_PN = 8'b1100_0101;
  localparam logic [7:0] V_RS = 8'b1110_1101;
  localparam logic [7:0] V_DI = 8'b1110_0101;
  localparam logic [7:0] V_ER = 8'b1100_0101;

  typedef struct {
    logic [8:0] exp;
    string      tag;
  } item_t;

  item_t q[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned step_no = 0;
  string       phase = "init";

  // Drive inputs for the next edge, then queue the output expected after it.
  task automatic step(input logic sr, input logic ack, input logic rn,
                      input logic [7:0] v, input logic e);
    item_t it;
    sleep_req = sr;
    pwr_ack   = ack;
    rst_n     = rn;
    @(posedge clk);
    it.exp = {v, e};
    it.tag = $sformatf("%s#%0d", phase, step_no);
    q.push_back(it);
    step_no++;
    @(negedge clk);
  endtask

  task automatic steps(input int unsigned n, input logic sr, input logic ack,
                       input logic [7:0] v, input logic e);
    for (int unsigned k = 0; k < n; k++) step(sr, ack, 1'b1, v, e);
  endtask

  // From ON: QUIESCE x4, SAVE, ISO x2, then first PWR_OFF cycle.
  task automatic enter_pwr_off(input logic e);
    steps(4, 1'b1, 1'b1, V_QU, e);
    step(1'b1, 1'b1, 1'b1, V_SV, e);
    steps(2, 1'b1, 1'b1, V_IS, e);
    step(1'b1, 1'b1, 1'b1, V_PO, e);
  endtask

  always @(negedge clk) begin
    item_t it;
    logic [8:0] act;
    if (q.size() > 0) begin
      it  = q.pop_front();
      act = {pwr_en, iso_en, clk_en, save, restore, wr_block, asleep, busy, err};
      n_cmp++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (pwr_en iso clk save rest wblk asleep busy err)",
                 it.tag, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sleep_req = 1'b0; pwr_ack = 1'b1;
    @(negedge clk);

    phase = "reset_idle";
    step(1'b0, 1'b1, 1'b0, V_ON, 1'b0);
    steps(10, 1'b0, 1'b1, V_ON, 1'b0);

    // Power-down: ack falls 3 cycles after pwr_en drops.
    phase = "power_down";
    enter_pwr_off(1'b0);
    steps(3, 1'b1, 1'b1, V_PO, 1'b0);
    step(1'b1, 1'b0, 1'b1, V_SL, 1'b0);
    steps(3, 1'b1, 1'b0, V_SL, 1'b0);

    // Wake: ack rises 2 cycles after pwr_en rises.
    phase = "wake";
    step(1'b0, 1'b0, 1'b1, V_PN, 1'b0);
    step(1'b0, 1'b0, 1'b1, V_PN, 1'b0);
    step(1'b0, 1'b1, 1'b1, V_RS, 1'b0);
    steps(2, 1'b0, 1'b1, V_DI, 1'b0);
    steps(3, 1'b0, 1'b1, V_ON, 1'b0);

    // Short sleep_req pulse aborts from QUIESCE.
    phase = "abort";
    steps(2, 1'b1, 1'b1, V_QU, 1'b0);
    steps(4, 1'b0, 1'b1, V_ON, 1'b0);

    // Switch never drops: timeout in PWR_OFF, then full restore path with err.
    phase = "off_timeout";
    enter_pwr_off(1'b0);
    steps(16, 1'b1, 1'b1, V_PO, 1'b0);
    step(1'b1, 1'b1, 1'b1, V_PN, 1'b1);
    step(1'b0, 1'b1, 1'b1, V_RS, 1'b1);
    steps(2, 1'b0, 1'b1, V_DI, 1'b1);
    steps(3, 1'b0, 1'b1, V_ON, 1'b1);

    phase = "reset_clr";
    step(1'b0, 1'b1, 1'b0, V_ON, 1'b0);

    // Ack drops in the very cycle the counter reaches the timeout: ack wins.
    phase = "ack_wins";
    enter_pwr_off(1'b0);
    steps(16, 1'b1, 1'b1, V_PO, 1'b0);
    step(1'b1, 1'b0, 1'b1, V_SL, 1'b0);

    // Switch never comes back: timeout in PWR_ON lands in ERR and stays.
    phase = "on_timeout";
    step(1'b0, 1'b0, 1'b1, V_PN, 1'b0);
    steps(16, 1'b0, 1'b0, V_PN, 1'b0);
    step(1'b0, 1'b0, 1'b1, V_ER, 1'b1);
    steps(2, 1'b1, 1'b1, V_ER, 1'b1);
    steps(2, 1'b0, 1'b1, V_ER, 1'b1);

    phase = "reset_err";
    step(1'b0, 1'b1, 1'b0, V_ON, 1'b0);
    steps(2, 1'b0, 1'b1, V_ON, 1'b0);

    // Reset during PWR_OFF returns straight to ON.
    phase = "reset_mid";
    enter_pwr_off(1'b0);
    steps(2, 1'b1, 1'b1, V_PO, 1'b0);
    step(1'b0, 1'b1, 1'b0, V_ON, 1'b0);
    steps(3, 1'b0, 1'b1, V_ON, 1'b0);

    @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
